// File: rtl/gba_linebuf_pkg.sv
// gba_linebuf_pkg
// Shared definitions for the per-background line buffer and its neighbours
// (tile drawers upstream, compositor downstream).
//   GBA_LINE_W          visible pixels per scanline
//   GBA_PIX_TRANSPARENT pixel word meaning "nothing drawn here"
//   gba_pixel_t         16-bit pixel word: bit 15 transparent, 14:0 BGR555
//   gba_sat_inc8        saturating 8-bit increment used by the debug counter
package gba_linebuf_pkg;

  localparam int GBA_LINE_W = 240;
  localparam logic [15:0] GBA_PIX_TRANSPARENT = 16'h8000;

  typedef logic [15:0] gba_pixel_t;

  function automatic logic [7:0] gba_sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/gba_linebuf_ram.sv
// gba_linebuf_ram
// Simple dual-port RAM holding both line banks, 15-bit BGR555 words.
// Address is {bank, x}; the column field is a full 8 bits so the array is
// padded to a power of two and never indexed out of range.
// Ports:
//   clk         clock
//   we/waddr/wdata  write port (bank, column, colour)
//   re/raddr    read request; q is registered and holds while re is low
//   q           read data, valid the cycle after re
module gba_linebuf_ram #(
  parameter int X_W = 8
) (
  input  logic           clk,
  input  logic           we,
  input  logic [X_W:0]   waddr,
  input  logic [14:0]    wdata,
  input  logic           re,
  input  logic [X_W:0]   raddr,
  output logic [14:0]    q
);

  localparam int DEPTH = 1 << (X_W + 1);

  logic [14:0] mem [DEPTH];

  // No reset on the array or the output register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/gba_bg_linebuffer.sv
// gba_bg_linebuffer
// Double-buffered line store for one background layer. The tile drawer
// writes the line being rendered into the write bank while the compositor
// reads the previous line from the other bank with one cycle of latency.
// Columns the drawer never writes read back as transparent, tracked by a
// per-bank valid vector that is wiped in one edge when a bank becomes the
// write bank.
// Ports:
//   fclk, reset_n        clock, synchronous active-low reset
//   swap                 line start; toggles wr_bank
//   pixel_we/pixel_x/pixeldata  drawer write stream
//   rd_en/rd_x           compositor read request
//   rd_data/rd_valid     read result, one cycle after rd_en
//   wr_bank              current write bank (debug)
//   wr_count/dup_write   debug statistics, present only when
//                        GBA_LINEBUF_STATS_EN is defined
module gba_bg_linebuffer
  import gba_linebuf_pkg::*;
#(
  parameter int LINE_W = GBA_LINE_W
) (
  input  logic        fclk,
  input  logic        reset_n,
  input  logic        swap,
  input  logic        pixel_we,
  input  logic [7:0]  pixel_x,
  input  gba_pixel_t  pixeldata,
  input  logic        rd_en,
  input  logic [7:0]  rd_x,
  output gba_pixel_t  rd_data,
  output logic        rd_valid,
  output logic        wr_bank
`ifdef GBA_LINEBUF_STATS_EN
  ,
  output logic [7:0]  wr_count,
  output logic        dup_write
`endif
);

  localparam logic [7:0] LINE_W_X = 8'(LINE_W);

  logic [LINE_W-1:0] valid_q [2];
  logic              rd_bank;
  logic              wr_acc;
  logic              rd_in_range;
  logic              rd_vbit;
  logic              rd_hit_q;
  logic [14:0]       ram_q;

  assign rd_bank     = ~wr_bank;
  assign wr_acc      = pixel_we && (pixel_x < LINE_W_X);
  assign rd_in_range = rd_x < LINE_W_X;

  // Index guarded so out-of-range columns never select past the vector.
  always_comb begin
    rd_vbit = 1'b0;
    if (rd_in_range) begin
      rd_vbit = valid_q[rd_bank][rd_x];
    end
  end

  gba_linebuf_ram #(
    .X_W (8)
  ) u_ram (
    .clk   (fclk),
    .we    (wr_acc),
    .waddr ({wr_bank, pixel_x}),
    .wdata (pixeldata[14:0]),
    .re    (rd_en),
    .raddr ({rd_bank, rd_x}),
    .q     (ram_q)
  );

  // The write always targets the pre-swap bank, and the swap clears the
  // other one, so a write and a clear in the same edge never touch the
  // same vector.
  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      wr_bank    <= 1'b0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
    end else begin
      if (wr_acc) begin
        valid_q[wr_bank][pixel_x] <= ~pixeldata[15];
      end
      if (swap) begin
        valid_q[rd_bank] <= '0;
        wr_bank          <= ~wr_bank;
      end
    end
  end

  // Hit flag is captured alongside the RAM read and, like the RAM output,
  // only updates on rd_en so rd_data holds between reads.
  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit_q <= rd_vbit;
      end
    end
  end

  assign rd_data = rd_hit_q ? {1'b0, ram_q} : GBA_PIX_TRANSPARENT;

`ifdef GBA_LINEBUF_STATS_EN
  logic [7:0]        wr_cnt;
  logic [7:0]        cnt_next;
  logic [LINE_W-1:0] wflag_q [2];
  logic              cur_flag;

  always_comb begin
    cur_flag = 1'b0;
    if (wr_acc) begin
      cur_flag = wflag_q[wr_bank][pixel_x];
    end
  end

  assign cnt_next = wr_acc ? gba_sat_inc8(wr_cnt) : wr_cnt;

  // The count latched on swap includes a write accepted in that same cycle.
  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      wr_cnt     <= 8'd0;
      wr_count   <= 8'd0;
      dup_write  <= 1'b0;
      wflag_q[0] <= '0;
      wflag_q[1] <= '0;
    end else begin
      dup_write <= wr_acc && cur_flag;
      if (wr_acc) begin
        wflag_q[wr_bank][pixel_x] <= 1'b1;
      end
      if (swap) begin
        wr_count         <= cnt_next;
        wr_cnt           <= 8'd0;
        wflag_q[rd_bank] <= '0;
      end else begin
        wr_cnt <= cnt_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gba_bg_linebuffer.sv
// tb_gba_bg_linebuffer
// Scoreboard bench for gba_bg_linebuffer: the driver updates a line-array
// reference model and queues expected read results; a negedge monitor pops
// and compares whenever rd_valid is seen.
module tb_gba_bg_linebuffer;
  import gba_linebuf_pkg::*;

  logic       fclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       swap = 1'b0;
  logic       pixel_we = 1'b0;
  logic [7:0] pixel_x = 8'd0;
  gba_pixel_t pixeldata = 16'd0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_x = 8'd0;
  gba_pixel_t rd_data;
  logic       rd_valid;
  logic       wr_bank;
`ifdef GBA_LINEBUF_STATS_EN
  logic [7:0] wr_count;
  logic       dup_write;
`endif

  gba_bg_linebuffer dut (
    .fclk      (fclk),
    .reset_n   (reset_n),
    .swap      (swap),
    .pixel_we  (pixel_we),
    .pixel_x   (pixel_x),
    .pixeldata (pixeldata),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_bank   (wr_bank)
`ifdef GBA_LINEBUF_STATS_EN
    ,
    .wr_count  (wr_count),
    .dup_write (dup_write)
`endif
  );

  always #5 fclk = ~fclk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  bit          rd_expect = 1'b0;
  bit          mon_en = 1'b0;
  logic [15:0] last_data = 16'h8000;

  // Reference model: each line is an array of colours, -1 meaning nothing drawn.
  int line_m [2][240];
  int wbank_m;
  int cnt_m;
  bit written_m [240];
  int wrcount_m;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 240; i++) line_m[b][i] = -1;
    for (int i = 0; i < 240; i++) written_m[i] = 1'b0;
    wbank_m   = 0;
    cnt_m     = 0;
    wrcount_m = 0;
  endtask

  function automatic logic [15:0] modelRead(input int x);
    int v;
    if (x >= 240) return 16'h8000;
    v = line_m[1 - wbank_m][x];
    if (v < 0) return 16'h8000;
    return 16'(v);
  endfunction

  // One clock of stimulus; the model is advanced with the same inputs.
  task automatic applyStimulus(input bit sw, input bit we, input int x,
                               input logic [15:0] d, input bit re, input int rx);
    bit dup;
    dup = 1'b0;
    if (re) exp_q.push_back(modelRead(rx));
    if (we && x < 240) begin
      dup = written_m[x];
      written_m[x] = 1'b1;
      if (cnt_m < 255) cnt_m++;
      line_m[wbank_m][x] = d[15] ? -1 : int'(d[14:0]);
    end
    if (sw) begin
      wrcount_m = cnt_m;
      cnt_m = 0;
      for (int i = 0; i < 240; i++) written_m[i] = 1'b0;
      wbank_m = 1 - wbank_m;
      for (int i = 0; i < 240; i++) line_m[wbank_m][i] = -1;
    end
    swap = sw; pixel_we = we; pixel_x = 8'(x); pixeldata = d;
    rd_en = re; rd_x = 8'(rx);
    @(posedge fclk);
    rd_expect = re;
    #1;
    swap = 1'b0; pixel_we = 1'b0; rd_en = 1'b0;
    checkOutput("wr_bank", 16'(wr_bank), 16'(wbank_m));
`ifdef GBA_LINEBUF_STATS_EN
    checkOutput("dup_write", 16'(dup_write), 16'(dup));
    if (sw) checkOutput("wr_count", 16'(wr_count), 16'(wrcount_m));
`else
    if (dup && sw) begin end
`endif
  endtask

  task automatic doReset(input bit idle_first);
    if (idle_first) applyStimulus(0, 0, 0, 16'h0, 0, 0);
    reset_n = 1'b0;
    @(posedge fclk);
    rd_expect = 1'b0;
    #1;
    reset_n = 1'b1;
    modelReset();
    last_data = 16'h8000;
    checkOutput("reset_rd_data", rd_data, 16'h8000);
    checkOutput("reset_rd_valid", 16'(rd_valid), 16'h0);
    checkOutput("reset_wr_bank", 16'(wr_bank), 16'h0);
`ifdef GBA_LINEBUF_STATS_EN
    checkOutput("reset_wr_count", 16'(wr_count), 16'h0);
    checkOutput("reset_dup_write", 16'(dup_write), 16'h0);
`endif
    checkOutput("reset_queue_empty", 16'(exp_q.size()), 16'h0);
    exp_q.delete();
  endtask

  task automatic readAll();
    for (int i = 0; i < 240; i++) applyStimulus(0, 0, 0, 16'h0, 1, i);
  endtask

  // Monitor: compare each presented read against the scoreboard.
  always @(negedge fclk) begin
    if (mon_en) begin
      checkOutput("rd_valid", 16'(rd_valid), 16'(rd_expect));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read: got %h expected nothing queued", rd_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          checkOutput("rd_data", rd_data, e);
          last_data = e;
        end
      end else begin
        checkOutput("rd_hold", rd_data, last_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge fclk);
    #1;
    doReset(1'b0);
    mon_en = 1'b1;

    // Basic write/read at both ends of the line
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 0, 16'h1234, 0, 0);
    applyStimulus(0, 1, 239, 16'h7FFF, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 239);
    applyStimulus(0, 0, 0, 16'h0, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);

    // Fill the write bank, then two swaps wipe it
    for (int i = 0; i < 240; i++) applyStimulus(0, 1, i, 16'($urandom_range(0, 16'h7FFF)), 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    readAll();

    // Transparent overwrite and out-of-range write
    applyStimulus(0, 1, 5, 16'h0ABC, 0, 0);
    applyStimulus(0, 1, 5, 16'h8000, 0, 0);
    applyStimulus(0, 1, 240, 16'h0001, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    readAll();
    applyStimulus(0, 0, 0, 16'h0, 1, 250);

    // Write, swap and read all in one cycle
    applyStimulus(0, 1, 7, 16'h0111, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 7, 16'h0042, 1, 7);
    applyStimulus(0, 0, 0, 16'h0, 1, 7);

    // Back-to-back swaps and randomized traffic
    applyStimulus(1, 0, 0, 16'h0, 1, 3);
    applyStimulus(1, 0, 0, 16'h0, 1, 4);
    for (int c = 0; c < 2000; c++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 255), 16'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 255));
    end

    // Mid-line reset discards both lines
    for (int i = 0; i < 100; i++) applyStimulus(0, 1, i, 16'($urandom_range(0, 16'h7FFF)), 0, 0);
    doReset(1'b1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    checkOutput("wr_bank_after_reset_swap", 16'(wr_bank), 16'h1);
    readAll();

`ifdef GBA_LINEBUF_STATS_EN
    // Full line of unique writes plus one repeat
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 240; i++) applyStimulus(0, 1, i, 16'($urandom_range(0, 16'h7FFF)), 0, 0);
    applyStimulus(0, 1, 10, 16'h0123, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    checkOutput("wr_count_241", 16'(wr_count), 16'd241);
`endif

    applyStimulus(0, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 0, 0);
    checkOutput("drain", 16'(exp_q.size()), 16'h0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
